if_unit: RTL and testbench
==========================

IF_UNIT -- requirements
Module: if_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port Stall  input  1  hazard stall: hold PC and IF/ID register.
REQ-005 SHALL provide port Flush  input  1  squash the instruction being written into IF/ID.
REQ-006 SHALL provide port Branch_Taken  input  1  EX-stage branch resolved taken.
REQ-007 SHALL provide port Branch_Addr  input  32  branch target.
REQ-008 SHALL provide port Jr  input  1  register-jump (jr/jalr) redirect from ID.
REQ-009 SHALL provide port Jr_Addr  input  32  register-jump target.
REQ-010 SHALL provide port Jump  input  1  j/jal redirect from ID.
REQ-011 SHALL provide port J_Addr  input  32  jump target ({PC+4[31:28], target26, 2'b00}).
REQ-012 SHALL provide port Instr_Addr  output  32  instruction memory address (= PC).
REQ-013 SHALL provide port Instr  input  32  instruction word, combinational read of Instr_Addr.
REQ-014 SHALL provide IF/ID outputs OP_ID[6], Rs_ID[5], Rt_ID[5], Rd_ID[5], shamt_ID[5], func_ID[6], imm16_ID[16], J_Target_ID[26], PC_Addr_ID[32] (PC+4 of that instruction), Valid_ID[1], all registered.

Function
REQ-015 SHALL hold a 32-bit PC register; Instr_Addr SHALL equal PC combinationally.
REQ-016 SHALL compute next PC by priority: reset -> RESET_PC; Branch_Taken -> Branch_Addr; Jr -> Jr_Addr; Jump -> J_Addr; Stall -> PC (hold); else PC+4.
REQ-017 SHALL force bits [1:0] of every loaded PC value to 2'b00 (misaligned targets truncated, no exception).
REQ-018 SHALL compute PC+4 modulo 2^32 (32'hFFFF_FFFC + 4 -> 32'h0000_0000).
REQ-019 SHALL, when any of Branch_Taken, Jr, Jump, Flush is high (and reset low), load a bubble into IF/ID: all instruction fields zero (sll $0,$0,0), PC_Addr_ID = 0, Valid_ID = 0.
REQ-020 SHALL, when Stall is high and no redirect/Flush is active, hold every IF/ID output unchanged.
REQ-021 SHALL otherwise capture Instr into IF/ID: OP_ID=Instr[31:26], Rs_ID=[25:21], Rt_ID=[20:16], Rd_ID=[15:11], shamt_ID=[10:6], func_ID=[5:0], imm16_ID=[15:0], J_Target_ID=[25:0], PC_Addr_ID=PC+4, Valid_ID=1.
REQ-022 SHALL give redirects precedence over Stall: a redirect concurrent with Stall SHALL still update PC and bubble IF/ID.
REQ-023 SHALL treat Flush without redirect as: PC advances per REQ-016 (holds if Stall), IF/ID bubbled.
REQ-024 SHALL have fetch latency of one cycle: instruction at PC appears on IF/ID outputs the edge after PC is presented.
REQ-025 SHALL produce the first valid IF/ID entry (from RESET_PC) on the first rising edge after reset deasserts.
REQ-026 SHALL contain no combinational path from Stall/Flush/redirect inputs to any IF/ID output.

Reset
REQ-027 SHALL, on a rising edge with reset high, set PC = RESET_PC and all IF/ID outputs to zero with Valid_ID = 0, overriding all other inputs.
REQ-028 SHALL, if reset asserts mid-stall or mid-redirect, discard that operation; no state from before reset persists.
REQ-029 SHALL hold outputs at reset values for every cycle reset stays high.

Verification
REQ-030 SHALL cover sequential fetch: reset release, Instr = 0x2008_0005 at PC 0 -> next edge OP_ID=6'h08, Rt_ID=8, imm16_ID=5, PC_Addr_ID=4, Valid_ID=1, PC=4.
REQ-031 SHALL cover stall: Stall high two cycles at PC=8 -> PC stays 8, IF/ID unchanged for both cycles, resumes PC=12 after release.
REQ-032 SHALL cover priority: Branch_Taken=1 (Branch_Addr=0x40), Jump=1 (J_Addr=0x80), Stall=1 same cycle -> PC=0x40, Valid_ID=0, all fields 0.
REQ-033 SHALL cover alignment and wrap: Jr_Addr=0x0000_0103 -> PC=0x100; PC=0xFFFF_FFFC sequential -> PC_Addr_ID=0, PC=0.
REQ-034 SHALL cover Flush alone at PC=0x20 -> PC=0x24, IF/ID bubble; reset asserted while Stall high -> PC=RESET_PC, Valid_ID=0.

Source files
------------

// File: rtl/if_unit.sv
// rtl/if_unit.sv - instruction fetch stage: PC register, next-PC select and IF/ID pipeline register
//
// Purpose:
//   Holds the program counter, presents it to instruction memory and captures
//   the returned instruction word, decoded into fields, into the IF/ID register.
//   Redirects (branch, register jump, jump) and Flush squash the captured word
//   into a bubble. Stall freezes both PC and IF/ID.
//
// Ports:
//   clk, reset                 - single clock, synchronous active-high reset
//   Stall, Flush               - hazard hold / squash of the IF/ID write
//   Branch_Taken, Branch_Addr  - EX-stage taken branch and its target
//   Jr, Jr_Addr                - ID-stage register jump and its target
//   Jump, J_Addr               - ID-stage j/jal and its target
//   Instr_Addr                 - instruction memory address (= PC)
//   Instr                      - instruction word read combinationally at Instr_Addr
//   *_ID                       - registered IF/ID fields, PC+4 and valid flag

module if_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Addr,
    input  logic        Jr,
    input  logic [31:0] Jr_Addr,
    input  logic        Jump,
    input  logic [31:0] J_Addr,
    output logic [31:0] Instr_Addr,
    input  logic [31:0] Instr,
    output logic [5:0]  OP_ID,
    output logic [4:0]  Rs_ID,
    output logic [4:0]  Rt_ID,
    output logic [4:0]  Rd_ID,
    output logic [4:0]  shamt_ID,
    output logic [5:0]  func_ID,
    output logic [15:0] imm16_ID,
    output logic [25:0] J_Target_ID,
    output logic [31:0] PC_Addr_ID,
    output logic        Valid_ID
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;
    logic        w_redirect;
    logic        w_bubble;

    // Natural 32-bit wrap: 0xFFFF_FFFC + 4 becomes 0.
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_redirect = Branch_Taken | Jr | Jump;
    assign w_bubble   = w_redirect | Flush;
    assign Instr_Addr = r_pc;

    // Redirect priority: oldest stage (EX branch) wins over ID-stage jumps.
    always_comb begin
        w_pc_next = w_pc_plus4;
        if (Branch_Taken) begin
            w_pc_next = Branch_Addr;
        end else if (Jr) begin
            w_pc_next = Jr_Addr;
        end else if (Jump) begin
            w_pc_next = J_Addr;
        end else if (Stall) begin
            w_pc_next = r_pc;
        end
    end

    // Low two bits are dropped on every load so misaligned targets silently truncate.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= {RESET_PC[31:2], 2'b00};
        end else begin
            r_pc <= {w_pc_next[31:2], 2'b00};
        end
    end

    // IF/ID register. Redirect/Flush beat Stall so a squashed slot never survives a stall.
    always_ff @(posedge clk) begin
        if (reset || w_bubble) begin
            OP_ID       <= '0;
            Rs_ID       <= '0;
            Rt_ID       <= '0;
            Rd_ID       <= '0;
            shamt_ID    <= '0;
            func_ID     <= '0;
            imm16_ID    <= '0;
            J_Target_ID <= '0;
            PC_Addr_ID  <= '0;
            Valid_ID    <= 1'b0;
        end else if (!Stall) begin
            OP_ID       <= Instr[31:26];
            Rs_ID       <= Instr[25:21];
            Rt_ID       <= Instr[20:16];
            Rd_ID       <= Instr[15:11];
            shamt_ID    <= Instr[10:6];
            func_ID     <= Instr[5:0];
            imm16_ID    <= Instr[15:0];
            J_Target_ID <= Instr[25:0];
            PC_Addr_ID  <= w_pc_plus4;
            Valid_ID    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_unit.sv
// tb/tb_if_unit.sv - directed self-checking bench for if_unit

module tb_if_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic        Flush;
    logic        Branch_Taken;
    logic [31:0] Branch_Addr;
    logic        Jr;
    logic [31:0] Jr_Addr;
    logic        Jump;
    logic [31:0] J_Addr;
    logic [31:0] Instr_Addr;
    logic [31:0] Instr;
    logic [5:0]  OP_ID;
    logic [4:0]  Rs_ID;
    logic [4:0]  Rt_ID;
    logic [4:0]  Rd_ID;
    logic [4:0]  shamt_ID;
    logic [5:0]  func_ID;
    logic [15:0] imm16_ID;
    logic [25:0] J_Target_ID;
    logic [31:0] PC_Addr_ID;
    logic        Valid_ID;

    int checks = 0;
    int passed = 0;

    if_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .Stall       (Stall),
        .Flush       (Flush),
        .Branch_Taken(Branch_Taken),
        .Branch_Addr (Branch_Addr),
        .Jr          (Jr),
        .Jr_Addr     (Jr_Addr),
        .Jump        (Jump),
        .J_Addr      (J_Addr),
        .Instr_Addr  (Instr_Addr),
        .Instr       (Instr),
        .OP_ID       (OP_ID),
        .Rs_ID       (Rs_ID),
        .Rt_ID       (Rt_ID),
        .Rd_ID       (Rd_ID),
        .shamt_ID    (shamt_ID),
        .func_ID     (func_ID),
        .imm16_ID    (imm16_ID),
        .J_Target_ID (J_Target_ID),
        .PC_Addr_ID  (PC_Addr_ID),
        .Valid_ID    (Valid_ID)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
        Branch_Taken = 1'b0; Branch_Addr = 32'h0;
        Jr = 1'b0; Jr_Addr = 32'h0; Jump = 1'b0; J_Addr = 32'h0;
        Instr = 32'h0;

        // Reset state
        step();
        chk("rst_pc", Instr_Addr, 32'h0);
        chk("rst_valid", {31'h0, Valid_ID}, 32'h0);
        chk("rst_pcid", PC_Addr_ID, 32'h0);
        // Reset held with a live instruction: outputs stay at reset values
        Instr = 32'h2008_0005;
        step();
        chk("rsthold_valid", {31'h0, Valid_ID}, 32'h0);
        chk("rsthold_op", {26'h0, OP_ID}, 32'h0);
        chk("rsthold_pc", Instr_Addr, 32'h0);

        // First fetch after release: addi $8,$0,5
        reset = 1'b0;
        step();
        chk("f1_op", {26'h0, OP_ID}, 32'h08);
        chk("f1_rs", {27'h0, Rs_ID}, 32'h0);
        chk("f1_rt", {27'h0, Rt_ID}, 32'h8);
        chk("f1_imm", {16'h0, imm16_ID}, 32'h5);
        chk("f1_pcid", PC_Addr_ID, 32'h4);
        chk("f1_valid", {31'h0, Valid_ID}, 32'h1);
        chk("f1_pc", Instr_Addr, 32'h4);

        // add $8,$9,$10 at PC 4
        Instr = 32'h012A_4020;
        step();
        chk("f2_rs", {27'h0, Rs_ID}, 32'h9);
        chk("f2_rt", {27'h0, Rt_ID}, 32'hA);
        chk("f2_rd", {27'h0, Rd_ID}, 32'h8);
        chk("f2_sh", {27'h0, shamt_ID}, 32'h0);
        chk("f2_fn", {26'h0, func_ID}, 32'h20);
        chk("f2_pcid", PC_Addr_ID, 32'h8);
        chk("f2_pc", Instr_Addr, 32'h8);

        // Two-cycle stall at PC 8
        Stall = 1'b1; Instr = 32'hFFFF_FFFF;
        step();
        chk("st1_pc", Instr_Addr, 32'h8);
        chk("st1_rs", {27'h0, Rs_ID}, 32'h9);
        chk("st1_fn", {26'h0, func_ID}, 32'h20);
        chk("st1_pcid", PC_Addr_ID, 32'h8);
        step();
        chk("st2_pc", Instr_Addr, 32'h8);
        chk("st2_rd", {27'h0, Rd_ID}, 32'h8);
        chk("st2_pcid", PC_Addr_ID, 32'h8);
        chk("st2_valid", {31'h0, Valid_ID}, 32'h1);
        // Release: lw $11,16($0) fetched from PC 8
        Stall = 1'b0; Instr = 32'h8C0B_0010;
        step();
        chk("rel_pc", Instr_Addr, 32'hC);
        chk("rel_op", {26'h0, OP_ID}, 32'h23);
        chk("rel_rt", {27'h0, Rt_ID}, 32'hB);
        chk("rel_pcid", PC_Addr_ID, 32'hC);

        // Branch beats Jump and Stall
        Branch_Taken = 1'b1; Branch_Addr = 32'h40;
        Jump = 1'b1; J_Addr = 32'h80; Stall = 1'b1; Instr = 32'h2008_0005;
        step();
        chk("pri_pc", Instr_Addr, 32'h40);
        chk("pri_valid", {31'h0, Valid_ID}, 32'h0);
        chk("pri_op", {26'h0, OP_ID}, 32'h0);
        chk("pri_rt", {27'h0, Rt_ID}, 32'h0);
        chk("pri_imm", {16'h0, imm16_ID}, 32'h0);
        chk("pri_jt", {6'h0, J_Target_ID}, 32'h0);
        chk("pri_pcid", PC_Addr_ID, 32'h0);
        Branch_Taken = 1'b0; Jump = 1'b0; Stall = 1'b0;

        // Misaligned register jump truncates
        Jr = 1'b1; Jr_Addr = 32'h0000_0103;
        step();
        chk("jr_pc", Instr_Addr, 32'h100);
        chk("jr_valid", {31'h0, Valid_ID}, 32'h0);

        // Wrap: jump to top of address space, then sequential fetch of j 1
        Jr_Addr = 32'hFFFF_FFFE;
        step();
        chk("top_pc", Instr_Addr, 32'hFFFF_FFFC);
        Jr = 1'b0; Instr = 32'h0800_0001;
        step();
        chk("wrap_pc", Instr_Addr, 32'h0);
        chk("wrap_pcid", PC_Addr_ID, 32'h0);
        chk("wrap_valid", {31'h0, Valid_ID}, 32'h1);
        chk("wrap_op", {26'h0, OP_ID}, 32'h2);
        chk("wrap_jt", {6'h0, J_Target_ID}, 32'h1);

        // Flush alone at PC 0x20
        Jump = 1'b1; J_Addr = 32'h20;
        step();
        chk("j_pc", Instr_Addr, 32'h20);
        Jump = 1'b0; Flush = 1'b1; Instr = 32'h2008_0005;
        step();
        chk("fl_pc", Instr_Addr, 32'h24);
        chk("fl_valid", {31'h0, Valid_ID}, 32'h0);
        chk("fl_op", {26'h0, OP_ID}, 32'h0);
        // Flush with Stall: PC holds, IF/ID still bubbled
        Stall = 1'b1;
        step();
        chk("flst_pc", Instr_Addr, 32'h24);
        chk("flst_valid", {31'h0, Valid_ID}, 32'h0);
        Flush = 1'b0;
        // Unstall one fetch so IF/ID holds a valid entry before reset
        Stall = 1'b0;
        step();
        chk("pre_valid", {31'h0, Valid_ID}, 32'h1);
        chk("pre_pcid", PC_Addr_ID, 32'h28);

        // Reset during stall and redirect overrides everything
        reset = 1'b1; Stall = 1'b1; Branch_Taken = 1'b1; Branch_Addr = 32'h40;
        step();
        chk("rs_pc", Instr_Addr, 32'h0);
        chk("rs_valid", {31'h0, Valid_ID}, 32'h0);
        chk("rs_pcid", PC_Addr_ID, 32'h0);
        chk("rs_rt", {27'h0, Rt_ID}, 32'h0);
        // First valid entry right after release
        reset = 1'b0; Stall = 1'b0; Branch_Taken = 1'b0; Instr = 32'h012A_4020;
        step();
        chk("post_pc", Instr_Addr, 32'h4);
        chk("post_valid", {31'h0, Valid_ID}, 32'h1);
        chk("post_pcid", PC_Addr_ID, 32'h4);
        chk("post_fn", {26'h0, func_ID}, 32'h20);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
